// File: rtl/jmp_lfo.sv
// jmp_lfo: prescaled triangle sweep of the FIR jmp offset between depth_min and depth_max
module jmp_lfo #(
  parameter int JMP_WIDTH  = 9,
  parameter int RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  smp_vld,
  input  logic [RATE_WIDTH-1:0] rate,
  input  logic [JMP_WIDTH-1:0]  step,
  input  logic [JMP_WIDTH-1:0]  depth_min,
  input  logic [JMP_WIDTH-1:0]  depth_max,
  output logic [JMP_WIDTH-1:0]  jmp,
  output logic                  jmp_upd,
  output logic                  dir
);
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
  state_t                state_q, state_d;
  logic [JMP_WIDTH-1:0]  jmp_q, jmp_d;
  logic                  upd_q, upd_d;
  logic                  dir_q, dir_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d, rate_m1;
  logic                  tick;
  logic [JMP_WIDTH:0]    up, lo;
  always_comb begin
    rate_m1 = (rate == '0) ? '0 : rate - 1'b1;
    tick    = smp_vld && (cnt_q >= rate_m1);
    up      = {1'b0, jmp_q} + {1'b0, step};
    lo      = {1'b0, depth_min} + {1'b0, step};
    state_d = state_q;
    jmp_d   = jmp_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE || !en) begin
      state_d = (state_q == IDLE && en) ? RISE : IDLE;
      jmp_d   = depth_min;
      cnt_d   = '0;
      dir_d   = 1'b1;
    end else begin
      cnt_d = smp_vld ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
      if (tick) begin
        if (depth_min >= depth_max) begin
          jmp_d = depth_min;
        end else if (jmp_q > depth_max || (jmp_q >= depth_min && state_q == RISE && up >= {1'b0, depth_max})) begin
          jmp_d   = depth_max;
          state_d = FALL;
          dir_d   = 1'b0;
        end else if (jmp_q < depth_min || (state_q == FALL && {1'b0, jmp_q} <= lo)) begin
          jmp_d   = depth_min;
          state_d = RISE;
          dir_d   = 1'b1;
        end else begin
          jmp_d = (state_q == RISE) ? up[JMP_WIDTH-1:0] : jmp_q - step;
        end
      end
    end
    upd_d = (jmp_d != jmp_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      jmp_q   <= '0;
      upd_q   <= 1'b0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      jmp_q   <= jmp_d;
      upd_q   <= upd_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end
  assign jmp     = jmp_q;
  assign jmp_upd = upd_q;
  assign dir     = dir_q;
endmodule

// File: tb/tb_jmp_lfo.sv
// tb_jmp_lfo: directed self-checking bench for jmp_lfo
module tb_jmp_lfo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        smp_vld = 1'b0;
  logic [15:0] rate = 16'd1;
  logic [8:0]  step = 9'd0;
  logic [8:0]  depth_min = 9'd0;
  logic [8:0]  depth_max = 9'd0;
  logic [8:0]  jmp;
  logic        jmp_upd;
  logic        dir;
  int          checks = 0;
  int          errors = 0;

  jmp_lfo dut (
    .clk(clk), .rst(rst), .en(en), .smp_vld(smp_vld), .rate(rate), .step(step),
    .depth_min(depth_min), .depth_max(depth_max), .jmp(jmp), .jmp_upd(jmp_upd), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; smp_vld = 1'b1; rate = 16'd1; step = 9'd10;
    depth_min = 9'd7; depth_max = 9'd40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'd0 || jmp_upd !== 1'b0 || dir !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold[%0d]: jmp=%0d upd=%b dir=%b, expected jmp=0 upd=0 dir=1", i, jmp, jmp_upd, dir);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (jmp !== 9'd7 || jmp_upd !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: jmp=%0d upd=%b, expected jmp=7 upd=1", jmp, jmp_upd);
    end
  endtask

  task automatic test_basic_sweep();
    int exp_j [10] = '{0, 10, 20, 30, 40, 30, 20, 10, 0, 10};
    logic exp_d [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    rate = 16'd1; step = 9'd10; depth_min = 9'd0; depth_max = 9'd40; smp_vld = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'(exp_j[i]) || jmp_upd !== (i != 0) || dir !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_sweep[%0d]: jmp=%0d upd=%b dir=%b, expected jmp=%0d upd=%b dir=%b",
                 i, jmp, jmp_upd, dir, exp_j[i], i != 0, exp_d[i]);
      end
    end
  endtask

  task automatic test_prescale();
    int exp_j [8] = '{5, 8, 11, 12, 9, 6, 5, 8};
    int k = 0;
    int last = 0;
    rate = 16'd4; step = 9'd3; depth_min = 9'd5; depth_max = 9'd12; smp_vld = 1'b0;
    do_reset();
    for (int i = 0; i < 80 && k < 8; i++) begin
      smp_vld = (i % 2 == 1);
      @(negedge clk);
      if (jmp_upd) begin
        checks++;
        if (jmp !== 9'(exp_j[k])) begin
          errors++;
          $display("FAIL prescale_val[%0d]: jmp=%0d, expected %0d", k, jmp, exp_j[k]);
        end
        if (k >= 2) begin
          checks++;
          if (i - last != 8) begin
            errors++;
            $display("FAIL prescale_gap[%0d]: gap=%0d clks, expected 8", k, i - last);
          end
        end
        last = i;
        k++;
      end
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL prescale_count: updates=%0d, expected 8", k);
    end
  endtask

  task automatic test_saturation();
    int exp_a [4] = '{500, 511, 500, 511};
    int exp_b [3] = '{0, 511, 0};
    rate = 16'd0; step = 9'd20; depth_min = 9'd500; depth_max = 9'd511; smp_vld = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'(exp_a[i])) begin
        errors++;
        $display("FAIL sat_high[%0d]: jmp=%0d, expected %0d", i, jmp, exp_a[i]);
      end
    end
    step = 9'd511; depth_min = 9'd0; depth_max = 9'd511;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'(exp_b[i])) begin
        errors++;
        $display("FAIL sat_full[%0d]: jmp=%0d, expected %0d", i, jmp, exp_b[i]);
      end
    end
  endtask

  task automatic test_degenerate();
    rate = 16'd1; step = 9'd10; depth_min = 9'd100; depth_max = 9'd50; smp_vld = 1'b1;
    do_reset();
    @(negedge clk);
    checks++;
    if (jmp !== 9'd100 || jmp_upd !== 1'b1) begin
      errors++;
      $display("FAIL degen_entry: jmp=%0d upd=%b, expected jmp=100 upd=1", jmp, jmp_upd);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'd100 || jmp_upd !== 1'b0) begin
        errors++;
        $display("FAIL degen_hold[%0d]: jmp=%0d upd=%b, expected jmp=100 upd=0", i, jmp, jmp_upd);
      end
    end
    depth_min = 9'd0; depth_max = 9'd40;
    do_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (jmp !== 9'd30 || dir !== 1'b1) begin
      errors++;
      $display("FAIL bound_pre: jmp=%0d dir=%b, expected jmp=30 dir=1", jmp, dir);
    end
    depth_max = 9'd20;
    @(negedge clk);
    checks++;
    if (jmp !== 9'd20 || dir !== 1'b0) begin
      errors++;
      $display("FAIL bound_clamp: jmp=%0d dir=%b, expected jmp=20 dir=0", jmp, dir);
    end
  endtask

  task automatic test_enable();
    int exp_j [4] = '{0, 0, 0, 10};
    rate = 16'd1; step = 9'd10; depth_min = 9'd0; depth_max = 9'd40; smp_vld = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (jmp !== 9'd0 || jmp_upd !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL en_drop: jmp=%0d upd=%b dir=%b, expected jmp=0 upd=1 dir=1", jmp, jmp_upd, dir);
    end
    @(negedge clk);
    checks++;
    if (jmp !== 9'd0 || jmp_upd !== 1'b0) begin
      errors++;
      $display("FAIL en_idle: jmp=%0d upd=%b, expected jmp=0 upd=0", jmp, jmp_upd);
    end
    rate = 16'd3;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'(exp_j[i])) begin
        errors++;
        $display("FAIL en_restart[%0d]: jmp=%0d, expected %0d", i, jmp, exp_j[i]);
      end
    end
    rate = 16'd1;
    repeat (4) @(negedge clk);
    checks++;
    if (jmp !== 9'd30 || dir !== 1'b0) begin
      errors++;
      $display("FAIL fall_pre: jmp=%0d dir=%b, expected jmp=30 dir=0", jmp, dir);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (jmp !== 9'd0 || dir !== 1'b1 || jmp_upd !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: jmp=%0d dir=%b upd=%b, expected jmp=0 dir=1 upd=0", jmp, dir, jmp_upd);
    end
    rst = 1'b1;
  endtask

  task automatic test_rate_shrink();
    int exp_j [3] = '{10, 10, 20};
    rate = 16'd8; step = 9'd10; depth_min = 9'd0; depth_max = 9'd40; smp_vld = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);
    checks++;
    if (jmp !== 9'd0) begin
      errors++;
      $display("FAIL shrink_pre: jmp=%0d, expected 0", jmp);
    end
    rate = 16'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (jmp !== 9'(exp_j[i])) begin
        errors++;
        $display("FAIL shrink[%0d]: jmp=%0d, expected %0d", i, jmp, exp_j[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_prescale();
    test_saturation();
    test_degenerate();
    test_enable();
    test_rate_shrink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
